traffic_sel_scheduler: RTL and testbench
========================================

TRAFFIC_SEL_SCHEDULER -- requirements
Module: traffic_sel_scheduler

Interface
REQ-001 SHALL have parameter HYST_N, default 3: consecutive disagreeing congestion samples needed to qualify a mode change (legal range 1..15).
REQ-002 SHALL have parameter MIN_HOLD_SEC, default 10: minimum seconds a mode is kept after a change (legal range 0..63).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port: tick_sec  input  1  one-cycle pulse, once per second, from the signal controller.
REQ-007 SHALL have port: cong_valid  input  1  qualifies cong_flag for one cycle.
REQ-008 SHALL have port: cong_flag  input  1  congestion class from image processing (1 = heavy).
REQ-009 SHALL have port: light_valid  input  1  one-cycle phase-boundary pulse from the signal controller.
REQ-010 SHALL have port: traffic_sel  output  1  applied mode, driven to the signal controller.
REQ-011 SHALL have port: sel_pending  output  1  change qualified and waiting for a phase boundary.
REQ-012 SHALL have port: sel_changed  output  1  one-cycle pulse in the cycle after traffic_sel toggles.
REQ-013 SHALL have port: hold_left  output  6  remaining minimum-hold seconds.
REQ-014 SHALL have port: state  output  2  FSM state code (STABLE=0, QUALIFY=1, ARMED=2, PENDING=3).

Function
REQ-015 SHALL ignore cong_flag whenever cong_valid=0.
REQ-016 SHALL define a "disagree sample" as cong_valid=1 with cong_flag != traffic_sel, and an "agree sample" as cong_valid=1 with cong_flag == traffic_sel.
REQ-017 SHALL keep a 4-bit hysteresis counter: +1 per disagree sample, saturating at HYST_N; cleared to 0 by any agree sample.
REQ-018 SHALL keep the hold counter (hold_left): decrement by 1 on tick_sec when nonzero; hold at 0 when zero; never wrap.
REQ-019 SHALL use FSM states: STABLE (counter=0), QUALIFY (0<counter<HYST_N), ARMED (counter=HYST_N, hold_left>0), PENDING (counter=HYST_N, hold_left=0).
REQ-020 SHALL transition STABLE->QUALIFY on a disagree sample, or STABLE->ARMED/PENDING directly when HYST_N=1, selected by hold_left.
REQ-021 SHALL transition QUALIFY->ARMED or PENDING on the sample that makes counter=HYST_N, selected by hold_left in that same cycle.
REQ-022 SHALL transition ARMED->PENDING in the cycle after hold_left reaches 0.
REQ-023 SHALL return from QUALIFY, ARMED or PENDING to STABLE on an agree sample, and SHALL deassert sel_pending in the following cycle.
REQ-024 SHALL assert sel_pending exactly while state=PENDING, registered.
REQ-025 SHALL, on light_valid=1 while state=PENDING:
  - toggle traffic_sel at the next edge
  - clear the counter
  - load hold_left with MIN_HOLD_SEC
  - enter STABLE
  - pulse sel_changed for one cycle after the toggle
REQ-026 SHALL NOT change traffic_sel on light_valid in STABLE, QUALIFY or ARMED.
REQ-027 SHALL, on an agree sample coinciding with light_valid in PENDING, give the agree sample priority: no toggle, return to STABLE.
REQ-028 SHALL, on a disagree sample coinciding with light_valid in QUALIFY, count the sample only; the toggle waits for a later light_valid.
REQ-029 SHALL, on tick_sec coinciding with a hold reload, take the reload (MIN_HOLD_SEC, no decrement).
REQ-030 SHALL, with MIN_HOLD_SEC=0, never enter ARMED.

Reset
REQ-031 SHALL, on reset assertion, asynchronously force: traffic_sel=0, sel_pending=0, sel_changed=0, hold_left=0, counter=0, state=STABLE.
REQ-032 SHALL, on reset mid-operation (any state, including PENDING with light_valid high), discard the pending change; no sel_changed pulse.
REQ-033 SHALL release reset synchronously-safe: first state update on the first rising clk edge after reset deasserts.

Verification
REQ-034 SHALL cover basic switch (defaults): 3 valid cong_flag=1 samples -> PENDING, sel_pending=1; light_valid -> traffic_sel=1, sel_changed pulse, hold_left=10.
REQ-035 SHALL cover glitch reject: samples 1,1,0,1 -> counter returns to 0 after third sample, ends at 1; no sel_pending, traffic_sel stays 0.
REQ-036 SHALL cover min hold: after a switch to 1, 3 samples of 0 within 10 ticks -> ARMED, sel_pending=0; light_valid ignored; after 10th tick_sec -> PENDING.
REQ-037 SHALL cover simultaneity: agree sample + light_valid in PENDING -> no toggle, state=STABLE; tick_sec + reload -> hold_left=10.
REQ-038 SHALL cover saturation: 20 consecutive disagree samples -> counter stays 3, hold_left never below 0.
REQ-039 SHALL cover reset in PENDING: assert reset with light_valid high -> all outputs 0 immediately, no toggle after release.

Source files
------------

// File: rtl/traffic_sel_scheduler.sv
// Chooses the signal-controller traffic mode from congestion samples, using hysteresis,
// a minimum hold time, and mode changes that are applied only on phase boundaries.
module traffic_sel_scheduler #(
  parameter int unsigned HYST_N       = 3,
  parameter int unsigned MIN_HOLD_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_sec,
  input  logic       cong_valid,
  input  logic       cong_flag,
  input  logic       light_valid,
  output logic       traffic_sel,
  output logic       sel_pending,
  output logic       sel_changed,
  output logic [5:0] hold_left,
  output logic [1:0] state
);

  localparam logic [1:0] STABLE  = 2'd0;
  localparam logic [1:0] QUALIFY = 2'd1;
  localparam logic [1:0] ARMED   = 2'd2;
  localparam logic [1:0] PENDING = 2'd3;

  localparam logic [3:0] HYST_MAX  = 4'(HYST_N);
  localparam logic [5:0] HOLD_LOAD = 6'(MIN_HOLD_SEC);

  logic [3:0] count;
  logic [3:0] count_next;
  logic [5:0] hold_next;
  logic [1:0] state_next;
  logic       agree;
  logic       disagree;
  logic       fire;

  always_comb begin
    agree    = cong_valid && (cong_flag == traffic_sel);
    disagree = cong_valid && (cong_flag != traffic_sel);
    // An agree sample outranks a coincident phase boundary.
    fire     = (state == PENDING) && light_valid && !agree;
  end

  always_comb begin
    count_next = count;
    if (fire || agree)
      count_next = '0;
    else if (disagree && (count < HYST_MAX))
      count_next = count + 4'd1;
  end

  always_comb begin
    hold_next = hold_left;
    if (fire)
      hold_next = HOLD_LOAD;
    else if (tick_sec && (hold_left != '0))
      hold_next = hold_left - 6'd1;
  end

  // ARMED and PENDING are chosen from the hold value before this cycle's tick.
  always_comb begin
    state_next = state;
    if (fire || agree) begin
      state_next = STABLE;
    end else begin
      case (state)
        STABLE, QUALIFY: begin
          if (disagree) begin
            if (count_next == HYST_MAX)
              state_next = (hold_left != '0) ? ARMED : PENDING;
            else
              state_next = QUALIFY;
          end
        end
        ARMED: begin
          if (hold_left == '0)
            state_next = PENDING;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      hold_left   <= '0;
      state       <= STABLE;
      sel_pending <= 1'b0;
      traffic_sel <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      count       <= count_next;
      hold_left   <= hold_next;
      state       <= state_next;
      sel_pending <= (state_next == PENDING);
      traffic_sel <= traffic_sel ^ fire;
      sel_changed <= fire;
    end
  end

endmodule

// File: tb/tb_traffic_sel_scheduler.sv
// Bench for traffic_sel_scheduler: a default instance and an HYST_N=1/MIN_HOLD_SEC=0 instance,
// both checked every cycle against a rule-level reference model.
module tb_traffic_sel_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_sec = 1'b0, cong_valid = 1'b0, cong_flag = 1'b0, light_valid = 1'b0;

  logic       ts [2];
  logic       sp [2];
  logic       sc [2];
  logic [5:0] hl [2];
  logic [1:0] st [2];

  int checks = 0;
  int errors = 0;

  // Model of the scheduling rules: qualified = enough disagreement seen, pending = allowed to switch.
  int m_sel [2], m_cnt [2], m_hold [2];
  bit m_qual [2], m_pend [2], m_chg [2];

  always #5 clk = ~clk;

  traffic_sel_scheduler #(.HYST_N(3), .MIN_HOLD_SEC(10)) dut_a (
    .clk(clk), .reset(reset), .tick_sec(tick_sec), .cong_valid(cong_valid),
    .cong_flag(cong_flag), .light_valid(light_valid), .traffic_sel(ts[0]),
    .sel_pending(sp[0]), .sel_changed(sc[0]), .hold_left(hl[0]), .state(st[0]));

  traffic_sel_scheduler #(.HYST_N(1), .MIN_HOLD_SEC(0)) dut_b (
    .clk(clk), .reset(reset), .tick_sec(tick_sec), .cong_valid(cong_valid),
    .cong_flag(cong_flag), .light_valid(light_valid), .traffic_sel(ts[1]),
    .sel_pending(sp[1]), .sel_changed(sc[1]), .hold_left(hl[1]), .state(st[1]));

  typedef struct packed {
    logic       t, cv, cf, lv;
    logic       sel, pend, chg;
    logic [5:0] hold;
    logic [1:0] stt;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_state(input int i);
    if (m_pend[i]) return 3;
    if (m_qual[i]) return 2;
    if (m_cnt[i] > 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 0; m_cnt[i] = 0; m_hold[i] = 0;
      m_qual[i] = 0; m_pend[i] = 0; m_chg[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit t, input bit cv, input bit cf, input bit lv);
    int h, mh;
    bit ag, dg, fire, nq, np;
    h  = (i == 0) ? 3 : 1;
    mh = (i == 0) ? 10 : 0;
    ag = cv && (int'(cf) == m_sel[i]);
    dg = cv && (int'(cf) != m_sel[i]);
    fire = m_pend[i] && lv && !ag;
    nq = m_qual[i];
    np = m_pend[i];
    if (fire || ag) begin
      nq = 0; np = 0;
    end else if (dg && !m_qual[i] && (m_cnt[i] + 1 >= h)) begin
      nq = 1; np = (m_hold[i] == 0);
    end else if (m_qual[i] && !m_pend[i] && m_hold[i] == 0) begin
      np = 1;
    end
    if (fire || ag) m_cnt[i] = 0;
    else if (dg) m_cnt[i] = (m_cnt[i] + 1 > h) ? h : m_cnt[i] + 1;
    if (fire) m_hold[i] = mh;
    else if (t && m_hold[i] > 0) m_hold[i] = m_hold[i] - 1;
    m_qual[i] = nq;
    m_pend[i] = np;
    m_sel[i]  = m_sel[i] ^ int'(fire);
    m_chg[i]  = fire;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d.traffic_sel", i), int'(ts[i]), m_sel[i]);
      check($sformatf("u%0d.sel_pending", i), int'(sp[i]), int'(m_pend[i]));
      check($sformatf("u%0d.sel_changed", i), int'(sc[i]), int'(m_chg[i]));
      check($sformatf("u%0d.hold_left", i), int'(hl[i]), m_hold[i]);
      check($sformatf("u%0d.state", i), int'(st[i]), m_state(i));
    end
    check("u0.counter", int'(dut_a.count), m_cnt[0]);
  endtask

  // Called at a falling edge: drive, let one rising edge happen, compare at the next falling edge.
  task automatic cycle(input bit t, input bit cv, input bit cf, input bit lv);
    tick_sec = t; cong_valid = cv; cong_flag = cf; light_valid = lv;
    @(posedge clk);
    model_step(0, t, cv, cf, lv);
    model_step(1, t, cv, cf, lv);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    //            t  cv cf lv  sel pend chg hold st
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  2'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  2'd3};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd10, 2'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd10, 2'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd9,  2'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd9,  2'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd9,  2'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8,  2'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd8,  2'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8,  2'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd8,  2'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd8,  2'd2};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    // Basic switch, then qualification under minimum hold.
    for (int k = 0; k < 13; k++) begin
      cycle(tbl[k].t, tbl[k].cv, tbl[k].cf, tbl[k].lv);
      check($sformatf("tbl%0d.sel", k),   int'(ts[0]), int'(tbl[k].sel));
      check($sformatf("tbl%0d.pend", k),  int'(sp[0]), int'(tbl[k].pend));
      check($sformatf("tbl%0d.chg", k),   int'(sc[0]), int'(tbl[k].chg));
      check($sformatf("tbl%0d.hold", k),  int'(hl[0]), int'(tbl[k].hold));
      check($sformatf("tbl%0d.state", k), int'(st[0]), int'(tbl[k].stt));
    end

    // Hold expires: ARMED persists one cycle after hold reaches 0, then PENDING.
    repeat (8) cycle(1, 0, 0, 0);
    check("armed_at_hold0.state", int'(st[0]), 2);
    check("armed_at_hold0.hold", int'(hl[0]), 0);
    cycle(0, 0, 0, 0);
    check("armed_to_pending.state", int'(st[0]), 3);
    check("armed_to_pending.pend", int'(sp[0]), 1);

    // Agree sample coinciding with a phase boundary wins.
    cycle(0, 1, 1, 1);
    check("agree_vs_light.state", int'(st[0]), 0);
    check("agree_vs_light.sel", int'(ts[0]), 1);
    check("agree_vs_light.chg", int'(sc[0]), 0);

    // Tick coinciding with the reload takes the reload.
    repeat (3) cycle(0, 1, 0, 0);
    check("requal.state", int'(st[0]), 3);
    cycle(1, 0, 0, 1);
    check("tick_reload.hold", int'(hl[0]), 10);
    check("tick_reload.sel", int'(ts[0]), 0);
    check("tick_reload.chg", int'(sc[0]), 1);

    // Glitch reject: 1,1,0,1.
    cycle(0, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 1, 0, 0);
    check("glitch.state_after_agree", int'(st[0]), 0);
    cycle(0, 1, 1, 0);
    check("glitch.state_end", int'(st[0]), 1);
    check("glitch.pend", int'(sp[0]), 0);
    check("glitch.sel", int'(ts[0]), 0);
    cycle(0, 1, 0, 0);

    // Saturation: 20 disagree samples with ticks.
    repeat (20) cycle(1, 1, 1, 0);
    check("sat.counter", int'(dut_a.count), 3);
    check("sat.hold", int'(hl[0]), 0);
    check("sat.state", int'(st[0]), 3);

    // Reset while PENDING with light_valid high.
    tick_sec = 1'b0; cong_valid = 1'b0; cong_flag = 1'b0; light_valid = 1'b1;
    #1 reset = 1'b1;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    cycle(0, 0, 0, 1);
    check("post_reset.sel", int'(ts[0]), 0);
    check("post_reset.chg", int'(sc[0]), 0);
    check("post_reset.state", int'(st[0]), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
